pong_match_ctrl: RTL and testbench
==================================

// Module: pong_match_ctrl
// PURPOSE
//   Match sequencer for the Pong datapath. Owns game flow:
//   - idle -> serve delay -> rally -> point accounting -> level-up or match over.
//   - Gates the ball engine (ball_hold, play_en), keeps both scores and the level.
//   - Emits one-cycle event pulses for the audio and score/LCD blocks.
//   Sits between the user buttons and the Ball/compPlayer/Score/Audio instances.
// PARAMETERS
//   WIN_SCORE  7      points needed to win a level (1..7)
//   MAX_LEVEL  7      final level; a win at this level ends the match (0..7)
//   SERVE_DLY  50_000_000  cycles ball is held at centre before each serve (>=1)
//   LVL_DLY    100_000_000 cycles spent in level-up celebration (>=1)
// PORTS
//   clk        in   1  system clock
//   reset      in   1  asynchronous, active-low reset
//   start      in   1  start/restart button, synchronous level, rising edge acts
//   pause      in   1  pause toggle button, synchronous level, rising edge acts
//   p1_point   in   1  one-cycle pulse from ball engine: player 1 scored
//   p2_point   in   1  one-cycle pulse from ball engine: player 2 scored
//   ball_hold  out  1  1 = ball engine held at centre (reset position)
//   play_en    out  1  1 = ball and paddles advance this cycle
//   p1_score   out  3  player 1 score, current level
//   p2_score   out  3  player 2 score, current level
//   level      out  3  current level, 0-based
//   point_evt  out  1  one-cycle pulse, valid point counted
//   lvl_up     out  1  one-cycle pulse on LVL_UP entry
//   win        out  1  one-cycle pulse when a player reaches WIN_SCORE
//   winner     out  1  0 = P1, 1 = P2; last level winner, held
//   state      out  3  IDLE=0 SERVE=1 PLAY=2 PAUSE=3 LVL_UP=4 OVER=5
// BEHAVIOUR
//   - Reset (async, reset=0):
//     - state=IDLE, ball_hold=1, play_en=0.
//     - Scores=0, level=0, winner=0, all pulses=0.
//     - Timer=0, edge-detect regs=0.
//   - start_r / pause_r: rising edges from one registered copy of each input. Decision made the same cycle as the edge.
//   - Timer: down-counter, width $clog2(max(SERVE_DLY,LVL_DLY)+1). Loaded with DLY-1; expiry when it reads 0.
//   - IDLE:
//     - ball_hold=1, play_en=0.
//     - start_r -> SERVE: scores=0, level=0, timer=SERVE_DLY-1.
//   - SERVE:
//     - ball_hold=1, play_en=0. Count down; at 0 -> PLAY.
//     - SERVE_DLY=1 gives exactly 1 cycle in SERVE.
//   - PLAY:
//     - ball_hold=0, play_en=1.
//     - Exactly one of p1/p2_point: scorer score+1, point_evt=1 next cycle.
//       - If new score==WIN_SCORE: win=1, winner=scorer; -> OVER if level==MAX_LEVEL, else -> LVL_UP, timer=LVL_DLY-1.
//       - Otherwise -> SERVE, timer=SERVE_DLY-1.
//     - Both pulses in one cycle: void rally, no score change, no point_evt, -> SERVE.
//     - Point has priority over pause_r in the same cycle.
//   - PAUSE:
//     - ball_hold=0, play_en=0: frozen, not recentred. Scores and timer unchanged.
//     - pause_r -> PLAY. Point pulses ignored.
//   - LVL_UP:
//     - lvl_up=1 on entry cycle only. level+1 saturating at 7, scores=0 on entry.
//     - ball_hold=1, play_en=0. Timer expiry -> SERVE, timer=SERVE_DLY-1.
//   - OVER:
//     - ball_hold=1, play_en=0. Scores frozen, winner held.
//     - start_r -> SERVE with scores=0, level=0.
//   - start_r in SERVE/PLAY/PAUSE/LVL_UP is ignored. Point pulses outside PLAY are ignored.
//   - Scores never exceed WIN_SCORE.
//   - Pulses (point_evt, lvl_up, win) are registered, exactly 1 cycle wide, never back-to-back from one event.
//   - Async reset mid-state returns everything to the reset values immediately.
// CONFIGURATION
//   PONG_PAUSE_EN
//   - Defined: PAUSE state and pause input are active as above.
//   - Undefined: pause is ignored, PAUSE is unreachable, state never reads 3.
//     The port stays in place so the top-level hookup is unchanged.
// TESTING
//   1. Reset, then start pulse, SERVE_DLY=4 -> state 1 for 4 cycles, then state 2 with play_en=1, ball_hold=0.
//   2. In PLAY, 3 p1_point pulses with serves between -> p1_score=3, three point_evt pulses, p2_score=0.
//   3. p1_point and p2_point in the same cycle -> scores unchanged, no point_evt, state->SERVE.
//   4. WIN_SCORE=2, level=0, P2 scores twice -> win=1, winner=1, lvl_up=1, level=1, scores=0; SERVE after LVL_DLY.
//   5. MAX_LEVEL=0, P1 reaches WIN_SCORE -> win pulse, state=5. Further points ignored. start -> SERVE, level=0.
//   6. PONG_PAUSE_EN defined: pause edge in PLAY -> state 3, play_en=0. Second edge -> PLAY. Reset during PAUSE -> IDLE.

Source files
------------

// File: rtl/pong_match_if.sv
`default_nettype none
// ============================================================================
// Module   : pong_match_if
// Purpose  : Button/ball-engine inputs and game-state outputs of the match
//            sequencer, bundled for the Pong top level.
// Revision : 1.0  initial release
// ============================================================================
interface pong_match_if;
  logic       start;
  logic       pause;
  logic       p1_point;
  logic       p2_point;
  logic       ball_hold;
  logic       play_en;
  logic [2:0] p1_score;
  logic [2:0] p2_score;
  logic [2:0] level;
  logic       point_evt;
  logic       lvl_up;
  logic       win;
  logic       winner;
  logic [2:0] state;

  modport master (
    input  start, pause, p1_point, p2_point,
    output ball_hold, play_en, p1_score, p2_score, level,
           point_evt, lvl_up, win, winner, state
  );

  modport slave (
    output start, pause, p1_point, p2_point,
    input  ball_hold, play_en, p1_score, p2_score, level,
           point_evt, lvl_up, win, winner, state
  );
endinterface
`default_nettype wire

// File: rtl/pong_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pong_match_ctrl
// Purpose  : Pong match sequencer: serve delay, rally, scoring, level-up and
//            match-over flow. Optional pause feature enabled by PONG_PAUSE_EN.
// Revision : 1.0  initial release
// ============================================================================
module pong_match_ctrl #(
  parameter int WIN_SCORE = 7,
  parameter int MAX_LEVEL = 7,
  parameter int SERVE_DLY = 50_000_000,
  parameter int LVL_DLY   = 100_000_000
) (
  input  wire logic    clk,
  input  wire logic    reset,
  pong_match_if.master bus
);

  localparam int              c_tmax      = (SERVE_DLY > LVL_DLY) ? SERVE_DLY : LVL_DLY;
  localparam int              c_tw        = $clog2(c_tmax + 1);
  localparam logic [c_tw-1:0] c_serve_ld  = c_tw'(SERVE_DLY - 1);
  localparam logic [c_tw-1:0] c_lvl_ld    = c_tw'(LVL_DLY - 1);
  localparam logic [2:0]      c_win_score = 3'(WIN_SCORE);
  localparam logic [2:0]      c_max_level = 3'(MAX_LEVEL);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_LVL_UP = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  state_t          r_state,     w_state_nxt;
  logic [c_tw-1:0] r_timer,     w_timer_nxt;
  logic [2:0]      r_p1_score,  w_p1_nxt;
  logic [2:0]      r_p2_score,  w_p2_nxt;
  logic [2:0]      r_level,     w_level_nxt;
  logic            r_winner,    w_winner_nxt;
  logic            r_point_evt, w_point_evt_nxt;
  logic            r_lvl_up,    w_lvl_up_nxt;
  logic            r_win,       w_win_nxt;
  logic            r_start_q;

  logic            w_start_rise;
  logic            w_pause_rise;
  logic [2:0]      w_p1_inc;
  logic [2:0]      w_p2_inc;
  logic            w_scored_win;

  assign w_start_rise = bus.start & ~r_start_q;
  assign w_p1_inc     = r_p1_score + 3'd1;
  assign w_p2_inc     = r_p2_score + 3'd1;
  // Only meaningful when exactly one point pulse is present
  assign w_scored_win = bus.p2_point ? (w_p2_inc == c_win_score)
                                     : (w_p1_inc == c_win_score);

`ifdef PONG_PAUSE_EN
  logic r_pause_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pause_q <= 1'b0;
    else        r_pause_q <= bus.pause;
  end

  assign w_pause_rise = bus.pause & ~r_pause_q;
`else
  logic w_unused_pause;

  assign w_unused_pause = bus.pause;
  assign w_pause_rise   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_p1_score  <= 3'd0;
      r_p2_score  <= 3'd0;
      r_level     <= 3'd0;
      r_winner    <= 1'b0;
      r_point_evt <= 1'b0;
      r_lvl_up    <= 1'b0;
      r_win       <= 1'b0;
      r_start_q   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_p1_score  <= w_p1_nxt;
      r_p2_score  <= w_p2_nxt;
      r_level     <= w_level_nxt;
      r_winner    <= w_winner_nxt;
      r_point_evt <= w_point_evt_nxt;
      r_lvl_up    <= w_lvl_up_nxt;
      r_win       <= w_win_nxt;
      r_start_q   <= bus.start;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_p1_nxt        = r_p1_score;
    w_p2_nxt        = r_p2_score;
    w_level_nxt     = r_level;
    w_winner_nxt    = r_winner;
    w_point_evt_nxt = 1'b0;
    w_lvl_up_nxt    = 1'b0;
    w_win_nxt       = 1'b0;

    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (w_start_rise) begin
          w_state_nxt = ST_SERVE;
          w_timer_nxt = c_serve_ld;
          w_p1_nxt    = 3'd0;
          w_p2_nxt    = 3'd0;
          w_level_nxt = 3'd0;
        end
      end

      ST_SERVE: begin
        if (r_timer == '0) w_state_nxt = ST_PLAY;
        else               w_timer_nxt = r_timer - 1'b1;
      end

      ST_PLAY: begin
        if (bus.p1_point ^ bus.p2_point) begin
          w_point_evt_nxt = 1'b1;
          w_p1_nxt        = bus.p1_point ? w_p1_inc : r_p1_score;
          w_p2_nxt        = bus.p2_point ? w_p2_inc : r_p2_score;
          if (w_scored_win) begin
            w_win_nxt    = 1'b1;
            w_winner_nxt = bus.p2_point;
            if (r_level == c_max_level) begin
              w_state_nxt = ST_OVER;
            end else begin
              // New level starts with a clean scoreboard in the entry cycle
              w_state_nxt  = ST_LVL_UP;
              w_timer_nxt  = c_lvl_ld;
              w_lvl_up_nxt = 1'b1;
              w_level_nxt  = (r_level == 3'd7) ? r_level : r_level + 3'd1;
              w_p1_nxt     = 3'd0;
              w_p2_nxt     = 3'd0;
            end
          end else begin
            w_state_nxt = ST_SERVE;
            w_timer_nxt = c_serve_ld;
          end
        end else if (bus.p1_point & bus.p2_point) begin
          w_state_nxt = ST_SERVE;
          w_timer_nxt = c_serve_ld;
        end else if (w_pause_rise) begin
          w_state_nxt = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (w_pause_rise) w_state_nxt = ST_PLAY;
      end

      ST_LVL_UP: begin
        if (r_timer == '0) begin
          w_state_nxt = ST_SERVE;
          w_timer_nxt = c_serve_ld;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // PAUSE freezes the ball in place rather than recentring it
  assign bus.ball_hold = (r_state != ST_PLAY) && (r_state != ST_PAUSE);
  assign bus.play_en   = (r_state == ST_PLAY);
  assign bus.p1_score  = r_p1_score;
  assign bus.p2_score  = r_p2_score;
  assign bus.level     = r_level;
  assign bus.point_evt = r_point_evt;
  assign bus.lvl_up    = r_lvl_up;
  assign bus.win       = r_win;
  assign bus.winner    = r_winner;
  assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_match_ctrl
// Purpose  : Directed plus random stimulus for pong_match_ctrl, checked
//            against a cycle-level behavioural model of the match rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_pong_match_ctrl;

  localparam int WIN_SCORE = 4;
  localparam int MAX_LEVEL = 1;
  localparam int SERVE_DLY = 4;
  localparam int LVL_DLY   = 5;
`ifdef PONG_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  pong_match_if bus ();

  pong_match_ctrl #(
    .WIN_SCORE (WIN_SCORE),
    .MAX_LEVEL (MAX_LEVEL),
    .SERVE_DLY (SERVE_DLY),
    .LVL_DLY   (LVL_DLY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase number, cycles left in a timed phase, scoreboard
  int m_phase, m_left, m_p1, m_p2, m_lvl, m_winner;
  int m_pevt, m_lup, m_win;
  bit m_prev_start, m_prev_pause;

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_p1 = 0; m_p2 = 0; m_lvl = 0; m_winner = 0;
    m_pevt = 0; m_lup = 0; m_win = 0;
    m_prev_start = 1'b0; m_prev_pause = 1'b0;
  endtask

  task automatic model_serve();
    m_phase = 1;
    m_left  = SERVE_DLY;
  endtask

  task automatic model_step(input bit st, input bit pa, input bit a, input bit b);
    bit sr, pr;
    int sc;
    sr = st && !m_prev_start;
    pr = pa && !m_prev_pause && PAUSE_EN;
    m_prev_start = st;
    m_prev_pause = pa;
    m_pevt = 0; m_lup = 0; m_win = 0;
    case (m_phase)
      0, 5: if (sr) begin
        m_p1 = 0; m_p2 = 0; m_lvl = 0;
        model_serve();
      end
      1: if (m_left == 1) m_phase = 2; else m_left--;
      2: begin
        if (a != b) begin
          m_pevt = 1;
          if (a) begin m_p1++; sc = m_p1; end
          else   begin m_p2++; sc = m_p2; end
          if (sc == WIN_SCORE) begin
            m_win = 1;
            m_winner = b ? 1 : 0;
            if (m_lvl == MAX_LEVEL) m_phase = 5;
            else begin
              m_phase = 4; m_left = LVL_DLY; m_lup = 1;
              m_lvl = (m_lvl < 7) ? m_lvl + 1 : 7;
              m_p1 = 0; m_p2 = 0;
            end
          end else model_serve();
        end else if (a && b) model_serve();
        else if (pr) m_phase = 3;
      end
      3: if (pr) m_phase = 2;
      4: if (m_left == 1) model_serve(); else m_left--;
      default: m_phase = 0;
    endcase
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all();
    chk("state",     8'(bus.state),     8'(m_phase));
    chk("ball_hold", 8'(bus.ball_hold), 8'((m_phase != 2 && m_phase != 3) ? 1 : 0));
    chk("play_en",   8'(bus.play_en),   8'((m_phase == 2) ? 1 : 0));
    chk("p1_score",  8'(bus.p1_score),  8'(m_p1));
    chk("p2_score",  8'(bus.p2_score),  8'(m_p2));
    chk("level",     8'(bus.level),     8'(m_lvl));
    chk("point_evt", 8'(bus.point_evt), 8'(m_pevt));
    chk("lvl_up",    8'(bus.lvl_up),    8'(m_lup));
    chk("win",       8'(bus.win),       8'(m_win));
    chk("winner",    8'(bus.winner),    8'(m_winner));
  endtask

  task automatic cyc(input bit st, input bit pa, input bit a, input bit b);
    @(negedge clk);
    bus.start = st; bus.pause = pa; bus.p1_point = a; bus.p2_point = b;
    model_step(st, pa, a, b);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    bus.start = 1'b0; bus.pause = 1'b0; bus.p1_point = 1'b0; bus.p2_point = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 8'(bus.state), 8'd0);
    chk("rst_hold",  8'(bus.ball_hold), 8'd1);
    chk("rst_play",  8'(bus.play_en), 8'd0);
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Start: four cycles of SERVE, then PLAY
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("serve_c1", 8'(bus.state), 8'd1);
    for (int i = 2; i <= SERVE_DLY; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("serve_cn", 8'(bus.state), 8'd1);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("play_state", 8'(bus.state), 8'd2);
    chk("play_en_on", 8'(bus.play_en), 8'd1);
    chk("hold_off",   8'(bus.ball_hold), 8'd0);

    // Three P1 points with serves in between
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("p1_evt", 8'(bus.point_evt), 8'd1);
      chk("p1_cnt", 8'(bus.p1_score), 8'(i));
      idle_cycles(SERVE_DLY);
    end
    chk("p2_zero", 8'(bus.p2_score), 8'd0);

    // Simultaneous points void the rally
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("void_state", 8'(bus.state), 8'd1);
    chk("void_evt",   8'(bus.point_evt), 8'd0);
    chk("void_p1",    8'(bus.p1_score), 8'd3);
    idle_cycles(SERVE_DLY);

    // P2 takes level 0
    for (int i = 1; i <= WIN_SCORE; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      if (i < WIN_SCORE) idle_cycles(SERVE_DLY);
    end
    chk("lv_win",    8'(bus.win), 8'd1);
    chk("lv_winner", 8'(bus.winner), 8'd1);
    chk("lv_up",     8'(bus.lvl_up), 8'd1);
    chk("lv_level",  8'(bus.level), 8'd1);
    chk("lv_p2",     8'(bus.p2_score), 8'd0);
    chk("lv_state",  8'(bus.state), 8'd4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lv_up_once", 8'(bus.lvl_up), 8'd0);
    idle_cycles(LVL_DLY - 1);
    chk("lv_to_serve", 8'(bus.state), 8'd1);
    idle_cycles(SERVE_DLY);

    // P1 wins the final level -> OVER, later points ignored
    for (int i = 1; i <= WIN_SCORE; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      if (i < WIN_SCORE) idle_cycles(SERVE_DLY);
    end
    chk("over_state", 8'(bus.state), 8'd5);
    chk("over_win",   8'(bus.win), 8'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("over_frozen", 8'(bus.p2_score), 8'd0);
    chk("over_p1",     8'(bus.p1_score), 8'(WIN_SCORE));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart", 8'(bus.state), 8'd1);
    chk("restart_lvl", 8'(bus.level), 8'd0);

    // Random play against the model, with one asynchronous reset midway
    for (int n = 0; n < 3000; n++) begin
      bit st, pa, a, b;
      int r;
      st = ($urandom_range(0, 24) == 0);
      pa = ($urandom_range(0, 9) == 0);
      r  = $urandom_range(0, 15);
      a  = (r == 0) || (r == 2 && $urandom_range(0, 3) == 0);
      b  = (r == 1) || (r == 2 && a);
      cyc(st, pa, a, b);
      if (n == 1500) begin
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("async_rst_state", 8'(bus.state), 8'd0);
        check_all();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
